axi_fb_burst_writer: RTL and testbench
======================================

// Module: axi_fb_burst_writer
// PURPOSE
// - AXI4 write master: streams 32-bit pixel words from the GPU raster pipeline into the DDR framebuffer as INCR bursts.
// - Counterpart of the AXI4 slave register path: this block drives AW/W and consumes B.
// - Per job: base address plus word count from the control logic; splits the job into bursts, reports done/err.
// PARAMETERS
// - ADDR_W     32  AXI byte-address width
// - DATA_W     32  data width; only 32 supported (awsize = 3'b010)
// - MAX_BURST  16  max beats per burst, 1..256 (awlen = beats-1)
// - CNT_W      20  width of the job word count
// PORTS
// - m_axi_aclk     in   1       single clock
// - m_axi_aresetn  in   1       synchronous, active-low reset
// - start_i        in   1       job strobe; sampled only when busy_o=0
// - base_addr_i    in   ADDR_W  job start byte address, [1:0] ignored (forced 0)
// - words_i        in   CNT_W   job length in 32-bit words
// - busy_o         out  1       job in progress
// - done_o         out  1       one-cycle pulse at job completion
// - err_o          out  1       sticky: some B response of the current job was not OKAY
// - pix_data_i     in   DATA_W  pixel stream data
// - pix_valid_i    in   1       pixel stream valid
// - pix_ready_o    out  1       pixel stream ready
// - M_AXI_aw*      out  -       awaddr ADDR_W, awlen 8, awsize 3, awburst 2, awcache 4, awlock 1, awprot 3, awvalid 1; awready in
// - M_AXI_w*       out  -       wdata DATA_W, wstrb 4, wlast 1, wvalid 1; wready in
// - M_AXI_b*       -    -       bresp[1:0] in, bvalid in, bready out
// BEHAVIOUR
// - Constant outputs: awsize=3'b010, awburst=2'b01 (INCR), awcache=4'b0011, awlock=0, awprot=0, wstrb=4'hF.
// - Reset: awvalid, wvalid, wlast, bready, pix_ready_o, busy_o, done_o, err_o all 0; awaddr/awlen 0; FSM=IDLE.
//   Reset mid-job abandons the job with no completion of outstanding AXI transactions.
// - FSM IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE. One burst outstanding at a time.
// - IDLE: on start_i, latch addr={base_addr_i[ADDR_W-1:2],2'b00} and rem=words_i; clear err_o; busy_o=1 next cycle.
//   words_i=0: go to DONE directly, no AXI traffic.
// - AW: beats = min(MAX_BURST, rem, (4096-addr[11:0])>>2); a burst never crosses a 4 KB boundary.
//   awvalid=1 with awaddr=addr, awlen=beats-1, registered and held stable until awready. First awvalid is the cycle after start.
// - W: wvalid=pix_valid_i, wdata=pix_data_i, pix_ready_o=wready (combinational pass-through, zero latency).
//   wlast=1 on beat index beats-1. The cycle wvalid&wready&wlast occurs -> B.
//   pix_ready_o=0 in every state other than W.
// - B: bready=1. On bvalid: if bresp!=2'b00 set err_o; addr+=beats*4; rem-=beats.
//   rem=0 -> DONE, else -> AW.
// - DONE: done_o=1 for exactly one cycle, busy_o drops the same cycle, -> IDLE. err_o holds until the next start.
// - start_i while busy_o=1 is ignored. Error responses do not abort the job; remaining bursts are still issued.
// - Address arithmetic is modulo 2^ADDR_W; wrap past top of memory is not checked.
// - AXI stability: no valid deasserts before its handshake; awaddr/awlen do not change while awvalid=1.
//   wdata stability is the producer's duty (valid/ready stream).
// STRUCTURE
// - gpu_axi_pkg (shared): AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_SIZE_4B,
//   AXI_4KB=4096, and the FSM state enum typedef.
// - Sub-module fb_burst_planner: combinational beats = min(MAX_BURST, rem, words-to-4KB).
//   All sequencing stays in the top module.
// TESTING
// - Job base=0x1000_0000, words=40, MAX_BURST=16, slave always ready -> awlen 15,15,7 at 0x1000_0000/0x40/0x80;
//   40 W beats, wlast on beats 16,32,40; one done_o pulse.
// - Job base=0x1000_0FF0, words=8 -> bursts awlen=3 at 0x...0FF0 and awlen=3 at 0x1000_1000; none crosses the 4 KB line.
// - words=0 -> done_o pulses 2 cycles after start_i; awvalid never asserted.
// - Random awready/wready/bvalid stalls plus pix_valid_i gaps, words=100 -> exactly 100 beats in order;
//   data matches the input sequence; valids never drop before their handshake.
// - Second burst's B returns SLVERR -> err_o=1 after that response; remaining bursts still issued;
//   err_o clears on the next start_i.
// - aresetn low during the W phase -> next cycle all valids/ready/busy=0 and FSM=IDLE;
//   a new job after reset completes normally.

Source files
------------

// File: rtl/gpu_axi_pkg.sv
// Shared AXI encodings and the burst-writer state type for the GPU memory path.
package gpu_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
   localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
   localparam logic [3:0] AXI_CACHE_BUF   = 4'b0011;
   localparam int         AXI_4KB         = 4096;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_DONE
   } fb_state_e;

endpackage

// File: rtl/fb_burst_planner.sv
// Burst length for the next AW: limited by the max burst, the words left and the 4 KB page.
module fb_burst_planner
   import gpu_axi_pkg::*;
#(
   parameter int CNT_W     = 20,
   parameter int MAX_BURST = 16
) (
   input  logic [9:0]       word_off,
   input  logic [CNT_W-1:0] rem,
   output logic [8:0]       beats
);

   logic [10:0] words_to_4kb;

   always_comb begin
      words_to_4kb = 11'(AXI_4KB >> 2) - {1'b0, word_off};
      beats        = 9'(MAX_BURST);
      if (words_to_4kb < 11'(beats)) beats = words_to_4kb[8:0];
      if (rem < CNT_W'(beats))       beats = rem[8:0];
   end

endmodule

// File: rtl/axi_fb_burst_writer.sv
// AXI4 write master streaming 32-bit pixel words into the framebuffer as INCR bursts.
//
// state   | meaning
// IDLE    | waiting for start_i
// AW      | address phase of the current burst, awvalid held
// W       | pixel stream passed through to the W channel
// B       | waiting for the write response, then advance addr/rem
// DONE    | one cycle before done_o pulses and busy_o drops
module axi_fb_burst_writer
   import gpu_axi_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 20
) (
   input  logic              m_axi_aclk,
   input  logic              m_axi_aresetn,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [CNT_W-1:0]  words_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   input  logic [DATA_W-1:0] pix_data_i,
   input  logic              pix_valid_i,
   output logic              pix_ready_o,
   output logic [ADDR_W-1:0] M_AXI_awaddr,
   output logic [7:0]        M_AXI_awlen,
   output logic [2:0]        M_AXI_awsize,
   output logic [1:0]        M_AXI_awburst,
   output logic [3:0]        M_AXI_awcache,
   output logic              M_AXI_awlock,
   output logic [2:0]        M_AXI_awprot,
   output logic              M_AXI_awvalid,
   input  logic              M_AXI_awready,
   output logic [DATA_W-1:0] M_AXI_wdata,
   output logic [3:0]        M_AXI_wstrb,
   output logic              M_AXI_wlast,
   output logic              M_AXI_wvalid,
   input  logic              M_AXI_wready,
   input  logic [1:0]        M_AXI_bresp,
   input  logic              M_AXI_bvalid,
   output logic              M_AXI_bready
);

   fb_state_e         state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx, base_al, awaddr_r;
   logic [CNT_W-1:0]  rem, rem_nx, plan_rem;
   logic [9:0]        plan_off;
   logic [8:0]        plan_beats, beats_r, beat_cnt;
   logic [7:0]        awlen_r;
   logic              awvalid_r, busy_r, done_r, err_r;
   logic              aw_hs, w_hs, b_hs, load_aw;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = ^base_addr_i[1:0];
   assign base_al  = {base_addr_i[ADDR_W-1:2], 2'b00};
   assign addr_nx  = addr + ADDR_W'({beats_r, 2'b00});
   assign rem_nx   = rem - CNT_W'(beats_r);

   // Plan from the job inputs in IDLE, otherwise from the post-burst position.
   assign plan_off = (state == ST_IDLE) ? base_al[11:2] : addr_nx[11:2];
   assign plan_rem = (state == ST_IDLE) ? words_i : rem_nx;

   fb_burst_planner #(
      .CNT_W     (CNT_W),
      .MAX_BURST (MAX_BURST)
   ) u_planner (
      .word_off (plan_off),
      .rem      (plan_rem),
      .beats    (plan_beats)
   );

   assign aw_hs   = awvalid_r & M_AXI_awready;
   assign w_hs    = M_AXI_wvalid & M_AXI_wready;
   assign b_hs    = (state == ST_B) & M_AXI_bvalid;
   assign load_aw = ((state == ST_IDLE) && start_i && (words_i != '0)) ||
                    (b_hs && (rem_nx != '0));

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) state <= ST_IDLE;
      else                state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start_i) state_nx = (words_i == '0) ? ST_DONE : ST_AW;
         ST_AW:   if (aw_hs) state_nx = ST_W;
         ST_W:    if (w_hs && M_AXI_wlast) state_nx = ST_B;
         ST_B:    if (b_hs) state_nx = (rem_nx == '0) ? ST_DONE : ST_AW;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         addr      <= '0;
         rem       <= '0;
         beats_r   <= '0;
         beat_cnt  <= '0;
         awaddr_r  <= '0;
         awlen_r   <= '0;
         awvalid_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         done_r <= (state == ST_DONE);
         if (state == ST_DONE) busy_r <= 1'b0;
         if ((state == ST_IDLE) && start_i) begin
            addr   <= base_al;
            rem    <= words_i;
            err_r  <= 1'b0;
            busy_r <= 1'b1;
         end
         if (aw_hs) begin
            awvalid_r <= 1'b0;
            beat_cnt  <= '0;
         end
         if (w_hs) beat_cnt <= beat_cnt + 9'd1;
         if (b_hs) begin
            if (M_AXI_bresp != AXI_RESP_OKAY) err_r <= 1'b1;
            addr <= addr_nx;
            rem  <= rem_nx;
         end
         if (load_aw) begin
            awvalid_r <= 1'b1;
            awaddr_r  <= (state == ST_IDLE) ? base_al : addr_nx;
            awlen_r   <= 8'(plan_beats - 9'd1);
            beats_r   <= plan_beats;
         end
      end
   end

   assign busy_o        = busy_r;
   assign done_o        = done_r;
   assign err_o         = err_r;
   assign M_AXI_awaddr  = awaddr_r;
   assign M_AXI_awlen   = awlen_r;
   assign M_AXI_awvalid = awvalid_r;
   assign M_AXI_awsize  = AXI_SIZE_4B;
   assign M_AXI_awburst = AXI_BURST_INCR;
   assign M_AXI_awcache = AXI_CACHE_BUF;
   assign M_AXI_awlock  = 1'b0;
   assign M_AXI_awprot  = 3'b000;
   assign M_AXI_wstrb   = 4'hF;
   assign M_AXI_wdata   = pix_data_i;
   assign M_AXI_wvalid  = (state == ST_W) & pix_valid_i;
   assign pix_ready_o   = (state == ST_W) & M_AXI_wready;
   assign M_AXI_wlast   = (state == ST_W) && (beat_cnt == beats_r - 9'd1);
   assign M_AXI_bready  = (state == ST_B);

endmodule

// File: tb/tb_axi_fb_burst_writer.sv
// Directed bench for axi_fb_burst_writer with a reactive AXI slave and pixel source.
module tb_axi_fb_burst_writer;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 20;

   logic              clk = 1'b0;
   logic              m_axi_aresetn;
   logic              start_i;
   logic [ADDR_W-1:0] base_addr_i;
   logic [CNT_W-1:0]  words_i;
   logic              busy_o, done_o, err_o;
   logic [DATA_W-1:0] pix_data_i;
   logic              pix_valid_i = 1'b0;
   logic              pix_ready_o;
   logic [ADDR_W-1:0] M_AXI_awaddr;
   logic [7:0]        M_AXI_awlen;
   logic [2:0]        M_AXI_awsize;
   logic [1:0]        M_AXI_awburst;
   logic [3:0]        M_AXI_awcache;
   logic              M_AXI_awlock;
   logic [2:0]        M_AXI_awprot;
   logic              M_AXI_awvalid;
   logic              M_AXI_awready = 1'b0;
   logic [DATA_W-1:0] M_AXI_wdata;
   logic [3:0]        M_AXI_wstrb;
   logic              M_AXI_wlast;
   logic              M_AXI_wvalid;
   logic              M_AXI_wready = 1'b0;
   logic [1:0]        M_AXI_bresp = 2'b00;
   logic              M_AXI_bvalid = 1'b0;
   logic              M_AXI_bready;

   always #5 clk = ~clk;

   axi_fb_burst_writer dut (
      .m_axi_aclk    (clk),
      .m_axi_aresetn (m_axi_aresetn),
      .start_i       (start_i),
      .base_addr_i   (base_addr_i),
      .words_i       (words_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .pix_data_i    (pix_data_i),
      .pix_valid_i   (pix_valid_i),
      .pix_ready_o   (pix_ready_o),
      .M_AXI_awaddr  (M_AXI_awaddr),
      .M_AXI_awlen   (M_AXI_awlen),
      .M_AXI_awsize  (M_AXI_awsize),
      .M_AXI_awburst (M_AXI_awburst),
      .M_AXI_awcache (M_AXI_awcache),
      .M_AXI_awlock  (M_AXI_awlock),
      .M_AXI_awprot  (M_AXI_awprot),
      .M_AXI_awvalid (M_AXI_awvalid),
      .M_AXI_awready (M_AXI_awready),
      .M_AXI_wdata   (M_AXI_wdata),
      .M_AXI_wstrb   (M_AXI_wstrb),
      .M_AXI_wlast   (M_AXI_wlast),
      .M_AXI_wvalid  (M_AXI_wvalid),
      .M_AXI_wready  (M_AXI_wready),
      .M_AXI_bresp   (M_AXI_bresp),
      .M_AXI_bvalid  (M_AXI_bvalid),
      .M_AXI_bready  (M_AXI_bready)
   );

   int vectors = 0;
   int miscompares = 0;

   bit          stall = 0, gaps = 0, pix_en = 0;
   int          pix_idx = 0, pix_total = 0;
   logic [31:0] pix_base = '0;
   int          b_pending = 0, b_done = 0, done_cnt = 0, prot_viol = 0, fail_idx = -1;
   logic [31:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];
   logic [31:0] w_data_q[$];
   bit          w_last_q[$];
   bit          aw_f = 0, w_f = 0, b_f = 0, prev_rstn = 0, prev_awv = 0, prev_wv = 0;
   logic [31:0] prev_awaddr = '0;
   logic [7:0]  prev_awlen = '0;

   // Slave and pixel source: drive at negedge, observe the coming handshakes 1 ns later.
   initial begin
      forever begin
         @(negedge clk);
         if (!(pix_en && pix_valid_i && !w_f))
            pix_valid_i = pix_en && (pix_idx < pix_total) && (!gaps || ($urandom_range(0, 2) != 0));
         pix_data_i    = pix_base + 32'(pix_idx);
         M_AXI_awready = !stall || ($urandom_range(0, 1) == 1);
         M_AXI_wready  = !stall || ($urandom_range(0, 1) == 1);
         if (!(M_AXI_bvalid && !b_f && b_pending > 0)) begin
            M_AXI_bvalid = (b_pending > 0) && (!stall || ($urandom_range(0, 2) == 0));
            M_AXI_bresp  = (b_done == fail_idx) ? 2'b10 : 2'b00;
         end
         #1;
         if (m_axi_aresetn && prev_rstn) begin
            if (prev_awv && !aw_f && (!M_AXI_awvalid || M_AXI_awaddr != prev_awaddr ||
                                      M_AXI_awlen != prev_awlen)) prot_viol++;
            if (prev_wv && !w_f && !M_AXI_wvalid) prot_viol++;
         end
         aw_f = M_AXI_awvalid && M_AXI_awready;
         w_f  = M_AXI_wvalid && M_AXI_wready;
         b_f  = M_AXI_bvalid && M_AXI_bready;
         if (m_axi_aresetn) begin
            if (aw_f) begin
               aw_addr_q.push_back(M_AXI_awaddr);
               aw_len_q.push_back(M_AXI_awlen);
            end
            if (w_f) begin
               w_data_q.push_back(M_AXI_wdata);
               w_last_q.push_back(M_AXI_wlast);
               pix_idx++;
               if (M_AXI_wlast) b_pending++;
            end
            if (b_f) begin
               b_pending--;
               b_done++;
            end
            if (done_o) done_cnt++;
         end else begin
            aw_f = 0;
            w_f  = 0;
            b_f  = 0;
         end
         prev_rstn   = m_axi_aresetn;
         prev_awv    = M_AXI_awvalid;
         prev_wv     = M_AXI_wvalid;
         prev_awaddr = M_AXI_awaddr;
         prev_awlen  = M_AXI_awlen;
      end
   end

   task automatic start_job(input logic [31:0] base, input int words, input logic [31:0] pbase);
      @(negedge clk);
      aw_addr_q.delete();
      aw_len_q.delete();
      w_data_q.delete();
      w_last_q.delete();
      done_cnt  = 0;
      b_done    = 0;
      b_pending = 0;
      prot_viol = 0;
      pix_idx   = 0;
      pix_total = words;
      pix_base  = pbase;
      pix_en    = 1;
      base_addr_i = base;
      words_i     = CNT_W'(words);
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      vectors++;
      if (done_cnt == 0) begin
         miscompares++;
         $display("FAIL %s done_o: got none, expected a pulse within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      m_axi_aresetn = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      vectors++;
      if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_wlast, M_AXI_bready, pix_ready_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_valids: got %b expected 00000",
                  {M_AXI_awvalid, M_AXI_wvalid, M_AXI_wlast, M_AXI_bready, pix_ready_o});
      end
      vectors++;
      if ({busy_o, done_o, err_o} !== 3'b0) begin
         miscompares++;
         $display("FAIL reset_status: got %b expected 000", {busy_o, done_o, err_o});
      end
      vectors++;
      if (M_AXI_awaddr !== 32'h0 || M_AXI_awlen !== 8'h0) begin
         miscompares++;
         $display("FAIL reset_aw: got %h/%h expected 0/0", M_AXI_awaddr, M_AXI_awlen);
      end
      vectors++;
      if ({M_AXI_awsize, M_AXI_awburst, M_AXI_awcache, M_AXI_awlock, M_AXI_awprot, M_AXI_wstrb} !==
          {3'b010, 2'b01, 4'b0011, 1'b0, 3'b000, 4'hF}) begin
         miscompares++;
         $display("FAIL constants: got %b expected %b",
                  {M_AXI_awsize, M_AXI_awburst, M_AXI_awcache, M_AXI_awlock, M_AXI_awprot, M_AXI_wstrb},
                  {3'b010, 2'b01, 4'b0011, 1'b0, 3'b000, 4'hF});
      end
      m_axi_aresetn = 1'b1;
   endtask

   task automatic test_multi_burst();
      logic [31:0] exp_a [3] = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080};
      logic [7:0]  exp_l [3] = '{8'd15, 8'd15, 8'd7};
      start_job(32'h1000_0000, 40, 32'hA000_0000);
      #2;
      vectors++;
      if ({busy_o, M_AXI_awvalid} !== 2'b11) begin
         miscompares++;
         $display("FAIL multi_first_aw busy/awvalid: got %b expected 11", {busy_o, M_AXI_awvalid});
      end
      vectors++;
      if (M_AXI_awaddr !== 32'h1000_0000 || M_AXI_awlen !== 8'd15) begin
         miscompares++;
         $display("FAIL multi_first_aw addr/len: got %h/%0d expected 10000000/15", M_AXI_awaddr, M_AXI_awlen);
      end
      wait_done(500, "multi");
      repeat (3) @(negedge clk);
      #2;
      vectors++;
      if (aw_addr_q.size() != 3) begin
         miscompares++;
         $display("FAIL multi_aw_count: got %0d expected 3", aw_addr_q.size());
      end
      for (int i = 0; i < 3 && i < aw_addr_q.size(); i++) begin
         vectors++;
         if (aw_addr_q[i] !== exp_a[i] || aw_len_q[i] !== exp_l[i]) begin
            miscompares++;
            $display("FAIL multi_aw[%0d]: got %h/%0d expected %h/%0d", i, aw_addr_q[i], aw_len_q[i], exp_a[i], exp_l[i]);
         end
      end
      vectors++;
      if (w_data_q.size() != 40) begin
         miscompares++;
         $display("FAIL multi_w_count: got %0d expected 40", w_data_q.size());
      end
      for (int i = 0; i < 40 && i < w_data_q.size(); i++) begin
         vectors++;
         if (w_data_q[i] !== 32'hA000_0000 + 32'(i) || w_last_q[i] != (i == 15 || i == 31 || i == 39)) begin
            miscompares++;
            $display("FAIL multi_w[%0d]: got %h last=%0d expected %h last=%0d", i, w_data_q[i], w_last_q[i],
                     32'hA000_0000 + 32'(i), (i == 15 || i == 31 || i == 39));
         end
      end
      vectors++;
      if (done_cnt != 1 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL multi_done: got pulses=%0d busy=%b expected 1/0", done_cnt, busy_o);
      end
   endtask

   task automatic test_4kb();
      logic [31:0] exp_a [2] = '{32'h1000_0FF0, 32'h1000_1000};
      start_job(32'h1000_0FF0, 8, 32'hB000_0000);
      wait_done(300, "4kb");
      vectors++;
      if (aw_addr_q.size() != 2) begin
         miscompares++;
         $display("FAIL 4kb_aw_count: got %0d expected 2", aw_addr_q.size());
      end
      for (int i = 0; i < 2 && i < aw_addr_q.size(); i++) begin
         vectors++;
         if (aw_addr_q[i] !== exp_a[i] || aw_len_q[i] !== 8'd3) begin
            miscompares++;
            $display("FAIL 4kb_aw[%0d]: got %h/%0d expected %h/3", i, aw_addr_q[i], aw_len_q[i], exp_a[i]);
         end
      end
      vectors++;
      if (w_data_q.size() != 8) begin
         miscompares++;
         $display("FAIL 4kb_w_count: got %0d expected 8", w_data_q.size());
      end
      for (int i = 0; i < 8 && i < w_data_q.size(); i++) begin
         vectors++;
         if (w_data_q[i] !== 32'hB000_0000 + 32'(i) || w_last_q[i] != (i == 3 || i == 7)) begin
            miscompares++;
            $display("FAIL 4kb_w[%0d]: got %h last=%0d expected %h last=%0d", i, w_data_q[i], w_last_q[i],
                     32'hB000_0000 + 32'(i), (i == 3 || i == 7));
         end
      end
   endtask

   task automatic test_zero();
      start_job(32'h1234_5678, 0, 32'h0);
      #2;
      vectors++;
      if ({busy_o, done_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL zero_cycle1 busy/done: got %b expected 10", {busy_o, done_o});
      end
      @(negedge clk);
      #2;
      vectors++;
      if ({busy_o, done_o} !== 2'b01) begin
         miscompares++;
         $display("FAIL zero_cycle2 busy/done: got %b expected 01", {busy_o, done_o});
      end
      @(negedge clk);
      #2;
      vectors++;
      if (done_o !== 1'b0 || done_cnt != 1) begin
         miscompares++;
         $display("FAIL zero_single_pulse: got done=%b pulses=%0d expected 0/1", done_o, done_cnt);
      end
      vectors++;
      if (aw_addr_q.size() != 0 || w_data_q.size() != 0) begin
         miscompares++;
         $display("FAIL zero_no_traffic: got aw=%0d w=%0d expected 0/0", aw_addr_q.size(), w_data_q.size());
      end
   endtask

   task automatic test_stalls();
      int lasts = 0;
      stall = 1;
      gaps  = 1;
      start_job(32'h2000_0000, 100, 32'hC000_0000);
      wait_done(5000, "stalls");
      vectors++;
      if (w_data_q.size() != 100) begin
         miscompares++;
         $display("FAIL stalls_w_count: got %0d expected 100", w_data_q.size());
      end
      for (int i = 0; i < w_data_q.size(); i++) begin
         if (w_last_q[i]) lasts++;
         vectors++;
         if (w_data_q[i] !== 32'hC000_0000 + 32'(i)) begin
            miscompares++;
            $display("FAIL stalls_w[%0d]: got %h expected %h", i, w_data_q[i], 32'hC000_0000 + 32'(i));
         end
      end
      vectors++;
      if (aw_addr_q.size() != 7 || lasts != 7) begin
         miscompares++;
         $display("FAIL stalls_bursts: got aw=%0d wlast=%0d expected 7/7", aw_addr_q.size(), lasts);
      end
      vectors++;
      if (aw_addr_q.size() == 7 && (aw_addr_q[6] !== 32'h2000_0180 || aw_len_q[6] !== 8'd3)) begin
         miscompares++;
         $display("FAIL stalls_last_aw: got %h/%0d expected 20000180/3", aw_addr_q[6], aw_len_q[6]);
      end
      vectors++;
      if (prot_viol != 0) begin
         miscompares++;
         $display("FAIL stalls_valid_stability: got %0d violations expected 0", prot_viol);
      end
      stall = 0;
      gaps  = 0;
   endtask

   task automatic test_slverr();
      int n;
      fail_idx = 1;
      start_job(32'h3000_0000, 48, 32'hD000_0000);
      n = 0;
      while (b_done < 1 && n < 200) begin @(negedge clk); #2; n++; end
      @(negedge clk);
      #2;
      vectors++;
      if (err_o !== 1'b0 || b_done < 1) begin
         miscompares++;
         $display("FAIL slverr_after_okay: got err=%b responses=%0d expected 0/>=1", err_o, b_done);
      end
      n = 0;
      while (b_done < 2 && n < 200) begin @(negedge clk); #2; n++; end
      @(negedge clk);
      #2;
      vectors++;
      if (err_o !== 1'b1 || b_done < 2) begin
         miscompares++;
         $display("FAIL slverr_after_err: got err=%b responses=%0d expected 1/>=2", err_o, b_done);
      end
      wait_done(300, "slverr");
      vectors++;
      if (aw_addr_q.size() != 3 || (aw_addr_q.size() == 3 && aw_addr_q[2] !== 32'h3000_0080)) begin
         miscompares++;
         $display("FAIL slverr_continues: got %0d bursts expected 3 ending at 30000080", aw_addr_q.size());
      end
      vectors++;
      if (err_o !== 1'b1 || w_data_q.size() != 48) begin
         miscompares++;
         $display("FAIL slverr_sticky: got err=%b beats=%0d expected 1/48", err_o, w_data_q.size());
      end
      fail_idx = -1;
   endtask

   task automatic test_err_clear();
      start_job(32'h3100_0000, 4, 32'hE000_0000);
      #2;
      vectors++;
      if ({busy_o, err_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL err_clear_on_start busy/err: got %b expected 10", {busy_o, err_o});
      end
      wait_done(200, "err_clear");
      vectors++;
      if (err_o !== 1'b0 || w_data_q.size() != 4 || aw_len_q.size() != 1) begin
         miscompares++;
         $display("FAIL err_clear_job: got err=%b beats=%0d bursts=%0d expected 0/4/1", err_o, w_data_q.size(), aw_len_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      start_job(32'h4000_0000, 32, 32'hF000_0000);
      while (w_data_q.size() < 5 && n < 200) begin @(negedge clk); #2; n++; end
      vectors++;
      if (!(M_AXI_wvalid === 1'b1 && busy_o === 1'b1)) begin
         miscompares++;
         $display("FAIL rst_mid_in_w wvalid/busy: got %b%b expected 11", M_AXI_wvalid, busy_o);
      end
      m_axi_aresetn = 1'b0;
      pix_en = 0;
      @(negedge clk);
      #2;
      vectors++;
      if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_wlast, M_AXI_bready, pix_ready_o, busy_o} !== 6'b0) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got %b expected 000000",
                  {M_AXI_awvalid, M_AXI_wvalid, M_AXI_wlast, M_AXI_bready, pix_ready_o, busy_o});
      end
      m_axi_aresetn = 1'b1;
      b_pending = 0;
      start_job(32'h5000_0000, 20, 32'h1111_0000);
      wait_done(300, "after_reset");
      vectors++;
      if (aw_addr_q.size() != 2 ||
          (aw_addr_q.size() == 2 && (aw_addr_q[0] !== 32'h5000_0000 || aw_len_q[0] !== 8'd15 ||
                                     aw_addr_q[1] !== 32'h5000_0040 || aw_len_q[1] !== 8'd3))) begin
         miscompares++;
         $display("FAIL after_reset_bursts: got %0d bursts expected 50000000/15 and 50000040/3", aw_addr_q.size());
      end
      vectors++;
      if (w_data_q.size() != 20) begin
         miscompares++;
         $display("FAIL after_reset_w_count: got %0d expected 20", w_data_q.size());
      end
      for (int i = 0; i < 20 && i < w_data_q.size(); i++) begin
         vectors++;
         if (w_data_q[i] !== 32'h1111_0000 + 32'(i)) begin
            miscompares++;
            $display("FAIL after_reset_w[%0d]: got %h expected %h", i, w_data_q[i], 32'h1111_0000 + 32'(i));
         end
      end
   endtask

   initial begin
      m_axi_aresetn = 1'b0;
      start_i       = 1'b0;
      base_addr_i   = '0;
      words_i       = '0;
      test_reset();
      test_multi_burst();
      test_4kb();
      test_zero();
      test_stalls();
      test_slverr();
      test_err_clear();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
